// File: rtl/alu_sequencer_if.sv
// Bus between the ALU sequencer and the instruction memory / ALU pair.
//   master : sequencer side (drives fetch request/address and ALU inputs)
//   slave  : memory + ALU side (returns fetch data, ALU result, flag, jump)
// Signals:
//   imem_req/imem_addr/imem_ack/imem_data : instruction fetch handshake
//   alu_clock                             : one-cycle execute strobe
//   alu_instr/alu_a/alu_b/alu_reg8        : opcode, operands, r8 contents
//   alu_value/alu_highlow                 : immediate and half select
//   alu_f1/alu_f2                         : latched flags to the ALU
//   alu_f3/alu_c                          : flag result and data result
//   alu_addrch/alu_naddr                  : jump request and target
interface alu_sequencer_if #(
  parameter int unsigned PC_W = 16
);
  logic            imem_req;
  logic [PC_W-1:0] imem_addr;
  logic            imem_ack;
  logic [31:0]     imem_data;
  logic            alu_clock;
  logic [5:0]      alu_instr;
  logic [31:0]     alu_a;
  logic [31:0]     alu_b;
  logic [31:0]     alu_reg8;
  logic [15:0]     alu_value;
  logic            alu_highlow;
  logic            alu_f1;
  logic            alu_f2;
  logic            alu_f3;
  logic [31:0]     alu_c;
  logic            alu_addrch;
  logic [31:0]     alu_naddr;

  modport master (
    output imem_req, imem_addr, alu_clock, alu_instr, alu_a, alu_b, alu_reg8,
           alu_value, alu_highlow, alu_f1, alu_f2,
    input  imem_ack, imem_data, alu_f3, alu_c, alu_addrch, alu_naddr
  );

  modport slave (
    input  imem_req, imem_addr, alu_clock, alu_instr, alu_a, alu_b, alu_reg8,
           alu_value, alu_highlow, alu_f1, alu_f2,
    output imem_ack, imem_data, alu_f3, alu_c, alu_addrch, alu_naddr
  );
endinterface

// File: rtl/alu_sequencer.sv
// CPU sequencer in front of the ALU: fetches 32-bit instruction words,
// decodes them into ALU operands, strobes the ALU for one cycle per
// instruction, writes results back to a local register file, latches
// flags and follows jump requests.
// Ports:
//   i_clock   : system clock, rising edge
//   i_reset_n : asynchronous active-low reset
//   i_run     : start fetching from PC (only sampled while idle)
//   o_halted  : HALT opcode reached; cleared only by reset
//   bus       : fetch handshake and ALU bus (alu_sequencer_if.master)
module alu_sequencer #(
  parameter int unsigned PC_W    = 16,
  parameter int unsigned NREGS   = 16,
  parameter logic [5:0]  HALT_OP = 6'd63
) (
  input  logic            i_clock,
  input  logic            i_reset_n,
  input  logic            i_run,
  output logic            o_halted,
  alu_sequencer_if.master bus
);

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StDecode,
    StExec,
    StWb,
    StHalt
  } state_e;

  state_e          r_state;
  state_e          w_state_d;

  logic [PC_W-1:0] r_pc;
  logic [31:0]     r_regs [NREGS];
  logic            r_f1;
  logic            r_f2;
  logic [31:0]     r_instr;

  // Registered ALU-facing outputs, held from DECODE through EXEC.
  logic [5:0]      r_alu_instr;
  logic [31:0]     r_alu_a;
  logic [31:0]     r_alu_b;
  logic [31:0]     r_alu_reg8;
  logic [15:0]     r_alu_value;
  logic            r_alu_highlow;

  // Strobes registered from the next state so they are glitch-free flops.
  logic            r_imem_req;
  logic            r_alu_clock;
  logic            r_halted;

  // ALU results captured at the end of EXEC.
  logic [31:0]     r_c;
  logic            r_f3;
  logic            r_addrch;
  logic [PC_W-1:0] r_naddr;

  logic [5:0]      w_op;
  logic [3:0]      w_rd;
  logic [3:0]      w_ra;
  logic [3:0]      w_rb;
  logic [31:0]     w_rd_a;
  logic [31:0]     w_rd_b;
  logic            w_unused;

  assign w_op = r_instr[31:26];
  assign w_rd = r_instr[25:22];
  assign w_ra = r_instr[21:18];
  assign w_rb = r_instr[3:0];

  // Bit 17 is reserved and the jump target is truncated to PC_W bits.
  assign w_unused = ^{r_instr[17], bus.alu_naddr};

  // Register reads; indices beyond the file read as zero.
  always_comb begin
    w_rd_a = '0;
    w_rd_b = '0;
    for (int i = 0; i < int'(NREGS); i++) begin
      if (int'(w_ra) == i) w_rd_a = r_regs[i];
      if (int'(w_rb) == i) w_rd_b = r_regs[i];
    end
  end

  always_comb begin
    w_state_d = r_state;
    case (r_state)
      StIdle:   if (i_run) w_state_d = StFetch;
      StFetch:  if (bus.imem_ack) w_state_d = StDecode;
      StDecode: w_state_d = (w_op == HALT_OP) ? StHalt : StExec;
      StExec:   w_state_d = StWb;
      StWb:     w_state_d = StFetch;
      StHalt:   w_state_d = StHalt;
      default:  w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state       <= StIdle;
      r_pc          <= '0;
      r_f1          <= 1'b0;
      r_f2          <= 1'b0;
      r_instr       <= '0;
      r_alu_instr   <= '0;
      r_alu_a       <= '0;
      r_alu_b       <= '0;
      r_alu_reg8    <= '0;
      r_alu_value   <= '0;
      r_alu_highlow <= 1'b0;
      r_imem_req    <= 1'b0;
      r_alu_clock   <= 1'b0;
      r_halted      <= 1'b0;
      r_c           <= '0;
      r_f3          <= 1'b0;
      r_addrch      <= 1'b0;
      r_naddr       <= '0;
      for (int i = 0; i < int'(NREGS); i++) r_regs[i] <= '0;
    end else begin
      r_state     <= w_state_d;
      r_imem_req  <= (w_state_d == StFetch);
      r_alu_clock <= (w_state_d == StExec);
      r_halted    <= (w_state_d == StHalt);

      if (r_state == StFetch && bus.imem_ack) r_instr <= bus.imem_data;

      if (r_state == StDecode) begin
        r_alu_instr   <= w_op;
        r_alu_a       <= w_rd_a;
        r_alu_b       <= w_rd_b;
        r_alu_reg8    <= r_regs[8];
        r_alu_value   <= r_instr[15:0];
        r_alu_highlow <= r_instr[16];
      end

      if (r_state == StExec) begin
        r_c      <= bus.alu_c;
        r_f3     <= bus.alu_f3;
        r_addrch <= bus.alu_addrch;
        r_naddr  <= bus.alu_naddr[PC_W-1:0];
      end

      if (r_state == StWb) begin
        r_pc <= r_addrch ? r_naddr : r_pc + PC_W'(1);
        if (w_op < 6'd8) begin
          // Out-of-range destinations match no entry and are dropped.
          for (int i = 0; i < int'(NREGS); i++) begin
            if (int'(w_rd) == i) r_regs[i] <= r_c;
          end
        end else if (w_op < 6'd14) begin
          r_f2 <= r_f1;
          r_f1 <= r_f3;
        end
      end
    end
  end

  assign bus.imem_req    = r_imem_req;
  assign bus.imem_addr   = r_pc;
  assign bus.alu_clock   = r_alu_clock;
  assign bus.alu_instr   = r_alu_instr;
  assign bus.alu_a       = r_alu_a;
  assign bus.alu_b       = r_alu_b;
  assign bus.alu_reg8    = r_alu_reg8;
  assign bus.alu_value   = r_alu_value;
  assign bus.alu_highlow = r_alu_highlow;
  assign bus.alu_f1      = r_f1;
  assign bus.alu_f2      = r_f2;
  assign o_halted        = r_halted;

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer: acts as instruction memory and ALU,
// and predicts operands, flags, register contents and PC with a plain
// architectural model (register array, PC, two flags).
module tb_alu_sequencer;

  logic clk;
  logic rst_n;
  logic run;
  logic halted;

  int n_pass;
  int n_total;

  logic [31:0] m_regs [16];
  logic [15:0] m_pc;
  logic        m_f1;
  logic        m_f2;

  alu_sequencer_if #(.PC_W(16)) bus_if ();

  alu_sequencer #(
    .PC_W   (16),
    .NREGS  (16),
    .HALT_OP(6'd63)
  ) dut (
    .i_clock  (clk),
    .i_reset_n(rst_n),
    .i_run    (run),
    .o_halted (halted),
    .bus      (bus_if.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic [31:0] mk(input logic [5:0] op, input logic [3:0] rd,
                                      input logic [3:0] ra, input logic hl,
                                      input logic [15:0] value);
    return {op, rd, ra, 1'($urandom_range(0, 1)), hl, value};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_regs[i] = '0;
    m_pc = '0;
    m_f1 = 1'b0;
    m_f2 = 1'b0;
  endtask

  task automatic start_run();
    int t;
    run = 1'b1;
    @(negedge clk);
    run = 1'b0;
    t = 0;
    while (!bus_if.imem_req && t < 10) begin
      @(negedge clk);
      t++;
    end
    check_eq("run_req", 64'(bus_if.imem_req), 64'd1);
  endtask

  // Entered at a negedge while the DUT is in FETCH; leaves at the next FETCH
  // (or in HALT / reset when the instruction halts or is aborted).
  task automatic do_instr(input logic [31:0] word, input int delay, input logic [31:0] c,
                          input logic f3, input logic ach, input logic [31:0] naddr,
                          input bit abort_exec);
    logic [5:0] op;
    logic [3:0] rd;
    logic [3:0] ra;
    logic [3:0] rb;
    op = word[31:26];
    rd = word[25:22];
    ra = word[21:18];
    rb = word[3:0];

    check_eq("fetch_req", 64'(bus_if.imem_req), 64'd1);
    check_eq("fetch_addr", 64'(bus_if.imem_addr), 64'(m_pc));
    for (int d = 0; d < delay; d++) begin
      bus_if.imem_ack  = 1'b0;
      bus_if.imem_data = $urandom;
      @(negedge clk);
      check_eq("wait_req", 64'(bus_if.imem_req), 64'd1);
      check_eq("wait_addr", 64'(bus_if.imem_addr), 64'(m_pc));
      check_eq("wait_aluclk", 64'(bus_if.alu_clock), 64'd0);
    end
    bus_if.imem_ack   = 1'b1;
    bus_if.imem_data  = word;
    bus_if.alu_c      = c;
    bus_if.alu_f3     = f3;
    bus_if.alu_addrch = ach;
    bus_if.alu_naddr  = naddr;
    @(negedge clk);
    // DECODE; a stray ack here must be ignored
    bus_if.imem_ack  = 1'b1;
    bus_if.imem_data = $urandom;
    check_eq("dec_req", 64'(bus_if.imem_req), 64'd0);
    check_eq("dec_aluclk", 64'(bus_if.alu_clock), 64'd0);
    @(negedge clk);
    bus_if.imem_ack = 1'b0;
    if (op == 6'd63) begin
      check_eq("halt_flag", 64'(halted), 64'd1);
      check_eq("halt_req", 64'(bus_if.imem_req), 64'd0);
      check_eq("halt_aluclk", 64'(bus_if.alu_clock), 64'd0);
      return;
    end
    // EXEC
    check_eq("exec_aluclk", 64'(bus_if.alu_clock), 64'd1);
    check_eq("exec_req", 64'(bus_if.imem_req), 64'd0);
    check_eq("exec_instr", 64'(bus_if.alu_instr), 64'(op));
    check_eq("exec_a", 64'(bus_if.alu_a), 64'(m_regs[ra]));
    check_eq("exec_b", 64'(bus_if.alu_b), 64'(m_regs[rb]));
    check_eq("exec_reg8", 64'(bus_if.alu_reg8), 64'(m_regs[8]));
    check_eq("exec_value", 64'(bus_if.alu_value), 64'(word[15:0]));
    check_eq("exec_hl", 64'(bus_if.alu_highlow), 64'(word[16]));
    check_eq("exec_flags", 64'({bus_if.alu_f1, bus_if.alu_f2}), 64'({m_f1, m_f2}));
    if (abort_exec) begin
      rst_n = 1'b0;
      #1;
      check_eq("abort_aluclk", 64'(bus_if.alu_clock), 64'd0);
      check_eq("abort_req", 64'(bus_if.imem_req), 64'd0);
      model_reset();
      return;
    end
    @(negedge clk);
    // WB: results must come from the EXEC-cycle values, not these
    bus_if.alu_c      = $urandom;
    bus_if.alu_f3     = 1'($urandom_range(0, 1));
    bus_if.alu_addrch = 1'($urandom_range(0, 1));
    bus_if.alu_naddr  = $urandom;
    check_eq("wb_aluclk", 64'(bus_if.alu_clock), 64'd0);
    check_eq("wb_req", 64'(bus_if.imem_req), 64'd0);
    if (op < 6'd8) m_regs[rd] = c;
    else if (op < 6'd14) begin
      m_f2 = m_f1;
      m_f1 = f3;
    end
    m_pc = ach ? naddr[15:0] : m_pc + 16'd1;
    @(negedge clk);
    check_eq("post_f1", 64'(bus_if.alu_f1), 64'(m_f1));
    check_eq("post_f2", 64'(bus_if.alu_f2), 64'(m_f2));
  endtask

  initial begin
    logic [5:0] op;
    int n_req;
    n_pass = 0;
    n_total = 0;
    run = 1'b0;
    rst_n = 1'b0;
    bus_if.imem_ack = 1'b0;
    bus_if.imem_data = '0;
    bus_if.alu_f3 = 1'b0;
    bus_if.alu_c = '0;
    bus_if.alu_addrch = 1'b0;
    bus_if.alu_naddr = '0;
    model_reset();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    check_eq("rst_req", 64'(bus_if.imem_req), 64'd0);
    check_eq("rst_aluclk", 64'(bus_if.alu_clock), 64'd0);
    check_eq("rst_halted", 64'(halted), 64'd0);
    check_eq("rst_addr", 64'(bus_if.imem_addr), 64'd0);
    check_eq("rst_ops", 64'(bus_if.alu_a | bus_if.alu_b | bus_if.alu_reg8), 64'd0);
    check_eq("rst_imm", 64'({bus_if.alu_instr, bus_if.alu_value, bus_if.alu_highlow,
                            bus_if.alu_f1, bus_if.alu_f2}), 64'd0);

    start_run();
    do_instr(mk(6'd5, 4'd1, 4'd0, 1'b1, 16'h1234), 0, 32'h0000_1234, 1'b0, 1'b0, '0, 1'b0);
    do_instr(mk(6'd0, 4'd3, 4'd1, 1'b0, 16'h0001), 5, 32'hCAFE_0003, 1'b0, 1'b0, '0, 1'b0);
    do_instr(mk(6'd8, 4'd0, 4'd3, 1'b0, 16'h0001), 0, 32'h1111_1111, 1'b1, 1'b0, '0, 1'b0);
    do_instr(mk(6'd8, 4'd0, 4'd3, 1'b0, 16'h0001), 1, 32'h2222_2222, 1'b0, 1'b0, '0, 1'b0);
    do_instr(mk(6'd14, 4'd5, 4'd1, 1'b0, 16'h0003), 0, 32'h3333_3333, 1'b1, 1'b1,
             32'h0001_0020, 1'b0);
    do_instr(mk(6'd20, 4'd5, 4'd1, 1'b0, 16'h0003), 0, 32'h4444_4444, 1'b0, 1'b1,
             32'h0000_FFFF, 1'b0);
    do_instr(mk(6'd0, 4'd8, 4'd8, 1'b0, 16'h0008), 0, 32'h5555_8888, 1'b0, 1'b0, '0, 1'b0);
    do_instr(mk(6'd1, 4'd8, 4'd8, 1'b0, 16'h0008), 0, 32'h6666_8888, 1'b0, 1'b0, '0, 1'b0);

    for (int k = 0; k < 120; k++) begin
      case ($urandom_range(0, 3))
        0, 3:    op = 6'($urandom_range(0, 7));
        1:       op = 6'($urandom_range(8, 13));
        default: op = 6'($urandom_range(14, 62));
      endcase
      do_instr(mk(op, 4'($urandom), 4'($urandom), 1'($urandom), 16'($urandom)),
               int'($urandom_range(0, 3)), $urandom, 1'($urandom),
               ($urandom_range(0, 3) == 0), $urandom, 1'b0);
    end

    // Reset in the middle of EXEC of a write to r2.
    do_instr(mk(6'd0, 4'd2, 4'd0, 1'b0, 16'h0000), 0, 32'hDEAD_BEEF, 1'b1, 1'b1,
             32'h0000_0077, 1'b1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("idle_req", 64'(bus_if.imem_req), 64'd0);
    check_eq("idle_addr", 64'(bus_if.imem_addr), 64'd0);
    start_run();
    do_instr(mk(6'd14, 4'd0, 4'd2, 1'b0, 16'h0002), 0, 32'h0, 1'b0, 1'b0, '0, 1'b0);

    do_instr(mk(6'd63, 4'd0, 4'd0, 1'b0, 16'h0000), 0, 32'h0, 1'b0, 1'b0, '0, 1'b0);
    n_req = 0;
    run = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (bus_if.imem_req || bus_if.alu_clock) n_req++;
    end
    run = 1'b0;
    check_eq("halt_quiet", 64'(n_req), 64'd0);
    check_eq("halt_hold", 64'(halted), 64'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/alu_sequencer.md
Name: alu_sequencer

Overview:
- Control end of the ALU interface: fetches 32-bit instruction words over a request/acknowledge port, decodes them, and drives the ALU operand, opcode, immediate and flag inputs.
- Strobes the ALU's clock/enable for exactly one cycle per instruction, writes the ALU result back to an internal register file, and latches the flag result.
- Applies jump requests (addrch/naddr) to its program counter.
- Sits between instruction memory and the ALU as the CPU sequencer.

Parameters:
- PC_W, 16, program-counter / instruction-address width (word addressed).
- NREGS, 16, register-file depth (must be >= 9; r8 is the jump-target register).
- HALT_OP, 63, opcode that stops execution.

Ports:
- clock  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- run  in  1  leave IDLE and start fetching at PC.
- imem_req  out  1  instruction fetch request.
- imem_addr  out  PC_W  fetch address (= PC).
- imem_ack  in  1  fetch data valid this cycle.
- imem_data  in  32  instruction word.
- alu_clock  out  1  one-cycle ALU execute strobe (drives the ALU clock input).
- alu_instr  out  6  ALU opcode.
- alu_a  out  32  operand A (= r[ra]).
- alu_b  out  32  operand B (= r[rb]).
- alu_reg8  out  32  r8 contents.
- alu_value  out  16  immediate.
- alu_highlow  out  1  immediate half select.
- alu_f1  out  1  flag F1.
- alu_f2  out  1  flag F2.
- alu_f3  in  1  compare/flag result from ALU.
- alu_c  in  32  ALU result.
- alu_addrch  in  1  jump request.
- alu_naddr  in  32  jump target.
- halted  out  1  HALT state reached.

Behaviour:
- Instruction format:
  - op = [31:26]
  - rd = [25:22]
  - ra = [21:18]
  - highlow = [16]
  - value = [15:0]
  - rb = [3:0], shared with value.
  - Bit 17 is ignored.
- Reset (async, reset_n=0):
  - State = IDLE, PC = 0, all registers = 0, F1 = F2 = 0, instruction latch = 0.
  - imem_req = 0, alu_clock = 0, halted = 0.
  - All alu_* outputs = 0.
  - Reset mid-operation aborts immediately; no writeback occurs.
- States:
  - IDLE: stay until run=1, then go to FETCH.
  - FETCH: imem_req=1 and imem_addr=PC. On imem_ack=1, latch imem_data and go to DECODE. imem_req stays high while ack=0, with no timeout.
  - DECODE: register alu_a/alu_b/alu_reg8/alu_value/alu_highlow/alu_instr from the latch and register file. If op == HALT_OP, go to HALT instead.
  - EXEC: alu_clock=1 for exactly this cycle. Sample alu_c, alu_f3, alu_addrch and alu_naddr at the end of the cycle. Go to WB.
  - WB:
    - op 0-7: r[rd] <= captured C.
    - op 8-13: F2 <= old F1, F1 <= captured F3.
    - op 14-62: no register or flag write.
    - PC: PC <= naddr[PC_W-1:0] if captured addrch=1, else PC+1.
    - Then go to FETCH.
  - HALT: halted=1, no further requests; exit only by reset.
- Timing:
  - Minimum 4 cycles per instruction (ack in first FETCH cycle).
  - alu_* operands are held stable from DECODE through EXEC.
- Width and boundary rules:
  - PC+1 wraps from 2^PC_W-1 to 0.
  - naddr upper bits are discarded.
  - rd, ra or rb >= NREGS: reads return 0 and writes are dropped.
  - rd == ra is allowed; the read uses the pre-write value.
  - Writeback to r8 affects alu_reg8 from the next DECODE.
- run is ignored outside IDLE; imem_ack is ignored outside FETCH.

Test Plan:
- Reset, run=1, imem returns {op=5, rd=1, highlow=1, value=16'h1234} with ack on the first FETCH cycle -> imem_addr=0, one alu_clock pulse in cycle 3 of the instruction; feed alu_c=32'h00001234 -> r1=32'h1234, next imem_addr=1, 4 cycles/instruction.
- Delay imem_ack by 5 cycles -> imem_req held high 6 cycles, imem_addr constant, no alu_clock pulse until after ack.
- op=8 with alu_f3=1, then op=8 with alu_f3=0 -> after 1st: F1=1, F2=0; after 2nd: F1=0, F2=1, on alu_f1/alu_f2.
- op=14 with alu_addrch=1, alu_naddr=32'h0001_0020 (PC_W=16) -> next imem_addr=16'h0020, no register write.
- PC=16'hFFFF, non-jump op 0 -> next imem_addr=0; op=63 -> halted=1, imem_req stays 0 for 20 cycles.
- Assert reset_n=0 during EXEC of op 0 (rd=2) -> alu_clock and imem_req drop immediately, r2=0, PC=0, state IDLE after release.
